mem_port_arbiter: RTL and testbench

// Shares one single-ported memory between the core's instruction-fetch requester and its data
// (load/store) requester. One transaction is outstanding at a time. Data wins by default, with
// an anti-starvation limit for fetch. Sits between the pipeline stage modules and the external

---
 rtl/mem_port_arbiter_pkg.sv | 26 ++
 rtl/mem_port_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the instruction/data memory port arbiter: FSM states, grant owner
// and the latched memory transaction.
package mem_port_arbiter_pkg;

  typedef logic [31:0] u32;
  typedef u32          word_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY_I,
    ARB_BUSY_D,
    ARB_RESP
  } arb_state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } arb_owner_t;

  typedef struct packed {
    logic  we;
    u32    addr;
    word_t wdata;
  } mem_txn_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Single-ported memory shared by instruction fetch and data load/store; one access in flight,
// data preferred, fetch guaranteed a slot after MAX_DSTREAK back-to-back data grants.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_DSTREAK = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_abort,
  output logic              i_resp,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_resp,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int              SW         = $clog2(MAX_DSTREAK + 1);
  localparam logic [SW-1:0]   STREAK_MAX = SW'(MAX_DSTREAK);

  arb_state_t          state_reg, state_next;
  arb_owner_t          owner_reg;
  logic [SW-1:0]       streak_reg;
  logic                drop_reg;
  logic                we_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [DATA_W-1:0]   rdata_reg;
  logic [DATA_W-1:0]   i_rdata_reg;
  logic [DATA_W-1:0]   d_rdata_reg;
  logic                grant_i, grant_d;
  logic                resp_active;

  always_comb begin
    state_next = state_reg;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    case (state_reg)
      ARB_IDLE: begin
        if (d_req && ((streak_reg < STREAK_MAX) || !i_req)) begin
          grant_d    = 1'b1;
          state_next = ARB_BUSY_D;
        end else if (i_req && !i_abort) begin
          grant_i    = 1'b1;
          state_next = ARB_BUSY_I;
        end
      end
      ARB_BUSY_I, ARB_BUSY_D: begin
        if (mem_ready) state_next = ARB_RESP;
      end
      ARB_RESP: state_next = ARB_IDLE;
      default:  state_next = ARB_IDLE;
    endcase
  end

  // mem_req is decoded from state so an asynchronous reset drops it immediately.
  assign mem_req     = (state_reg == ARB_BUSY_I) || (state_reg == ARB_BUSY_D);
  assign mem_we      = mem_req && we_reg;
  assign mem_addr    = addr_reg;
  assign mem_wdata   = wdata_reg;

  // A fetch squashed in flight, or aborted in its response cycle, is never answered.
  assign resp_active = (state_reg == ARB_RESP);
  assign i_resp      = resp_active && (owner_reg == OWN_I) && !drop_reg && !i_abort;
  assign d_resp      = resp_active && (owner_reg == OWN_D);
  assign i_rdata     = i_resp ? rdata_reg : i_rdata_reg;
  assign d_rdata     = d_resp ? rdata_reg : d_rdata_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= ARB_IDLE;
      owner_reg   <= OWN_I;
      drop_reg    <= 1'b0;
      we_reg      <= 1'b0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      rdata_reg   <= '0;
      i_rdata_reg <= '0;
      d_rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (grant_d) begin
        owner_reg <= OWN_D;
        we_reg    <= d_we;
        addr_reg  <= d_addr;
        wdata_reg <= d_wdata;
      end else if (grant_i) begin
        owner_reg <= OWN_I;
        we_reg    <= 1'b0;
        addr_reg  <= i_addr;
        wdata_reg <= '0;
      end
      if (mem_req && mem_ready) rdata_reg <= mem_rdata;
      if ((state_reg == ARB_BUSY_I) && i_abort) begin
        drop_reg <= 1'b1;
      end else if (resp_active) begin
        drop_reg <= 1'b0;
      end
      if (i_resp) i_rdata_reg <= rdata_reg;
      if (d_resp) d_rdata_reg <= rdata_reg;
    end
  end

  // Streak counts data grants that made a waiting fetch stand aside.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      streak_reg <= '0;
    end else if (!i_req || grant_i) begin
      streak_reg <= '0;
    end else if (grant_d && (streak_reg < STREAK_MAX)) begin
      streak_reg <= streak_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: expected grants and responses are queued by the
// stimulus and checked by an independent monitor against a simple memory responder.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_req = 1'b0, i_abort = 1'b0, i_resp;
  logic [31:0] i_addr = '0, i_rdata;
  logic        d_req = 1'b0, d_we = 1'b0, d_resp;
  logic [31:0] d_addr = '0, d_wdata = '0, d_rdata;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  mem_port_arbiter #(.MAX_DSTREAK(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_abort(i_abort), .i_resp(i_resp), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_resp(d_resp),
    .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  initial forever #5 clk = ~clk;

  typedef struct { bit is_d; bit chk_data; logic [31:0] data; } resp_exp_t;
  typedef struct { bit we; logic [31:0] addr; logic [31:0] wdata; } grant_exp_t;

  resp_exp_t   resp_q[$];
  grant_exp_t  grant_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] mem_model [logic [31:0]];
  bit          resp_enable = 1'b1;
  logic [31:0] t4_addr [6] = '{32'h100, 32'h204, 32'h208, 32'h20C, 32'h210, 32'h214};
  logic [31:0] t4_data [6] = '{32'hDEADBEEF, 32'hA0000001, 32'hA0000002,
                               32'hA0000003, 32'hA0000004, 32'hA0000005};

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic push_grant(bit we, logic [31:0] a, logic [31:0] wd);
    grant_exp_t g;
    g.we = we; g.addr = a; g.wdata = wd;
    grant_q.push_back(g);
  endtask

  task automatic push_resp(bit is_d, bit chk_data, logic [31:0] data);
    resp_exp_t r;
    r.is_d = is_d; r.chk_data = chk_data; r.data = data;
    resp_q.push_back(r);
  endtask

  // Memory responder: mem_ready pulses in the second cycle of each access.
  initial begin
    int age;
    age = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (mem_ready) begin
        mem_ready = 1'b0;
        age = 0;
      end else if (mem_req) begin
        if (age >= 1 && resp_enable) begin
          mem_ready = 1'b1;
          if (mem_we) begin
            mem_model[mem_addr] = mem_wdata;
            mem_rdata = 32'h0;
          end else begin
            mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'hBAD0BAD0;
          end
        end else begin
          age++;
        end
      end else begin
        age = 0;
      end
    end
  end

  // Monitor: every new memory access and every response is matched to the queues.
  initial begin
    logic       prev_req;
    grant_exp_t g;
    resp_exp_t  r;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_req && !prev_req) begin
        if (grant_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL grant: unexpected access addr 0x%08h, expected none", mem_addr);
        end else begin
          g = grant_q.pop_front();
          chk("grant_we", 32'(mem_we), 32'(g.we));
          chk("grant_addr", mem_addr, g.addr);
          if (g.we) chk("grant_wdata", mem_wdata, g.wdata);
        end
      end
      prev_req = mem_req;
      if (i_resp || d_resp) begin
        if (resp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL resp: unexpected i_resp=%0b d_resp=%0b, expected none", i_resp, d_resp);
        end else begin
          r = resp_q.pop_front();
          chk("resp_is_data", 32'(d_resp), 32'(r.is_d));
          if (r.chk_data) chk(r.is_d ? "d_rdata" : "i_rdata", r.is_d ? d_rdata : i_rdata, r.data);
        end
      end
    end
  end

  task automatic wait_i_resp(int budget, output int cycles);
    cycles = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      cycles++;
      if (i_resp) return;
    end
    n_checks++; n_fail++;
    $display("FAIL i_resp_timeout: got no i_resp, expected one within %0d cycles", budget);
  endtask

  task automatic wait_d_resp(int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (d_resp) return;
    end
    n_checks++; n_fail++;
    $display("FAIL d_resp_timeout: got no d_resp, expected one within %0d cycles", budget);
  endtask

  task automatic wait_mem_req(int budget);
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (mem_req) return;
    end
    n_checks++; n_fail++;
    $display("FAIL mem_req_timeout: got no mem_req, expected one within %0d cycles", budget);
  endtask

  task automatic fetch(logic [31:0] a, output int cycles);
    i_req = 1'b1; i_addr = a;
    wait_i_resp(60, cycles);
    @(posedge clk); #1;
    i_req = 1'b0;
  endtask

  task automatic data_op(bit we, logic [31:0] a, logic [31:0] wd);
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
    wait_d_resp(60);
    @(posedge clk); #1;
    d_req = 1'b0;
  endtask

  initial begin
    int cyc;
    mem_model[32'h10] = 32'h8C220004;
    mem_model[32'h14] = 32'h00000013;
    mem_model[32'h18] = 32'h24420001;
    mem_model[32'h30] = 32'h11111111;
    mem_model[32'h40] = 32'h22222222;
    for (int k = 1; k < 6; k++) mem_model[t4_addr[k]] = t4_data[k];

    // Reset held with a fetch pending, then released.
    i_req = 1'b1; i_addr = 32'h10;
    repeat (3) begin
      @(negedge clk);
      chk("reset_mem_req", 32'(mem_req), 32'h0);
      chk("reset_i_resp", 32'(i_resp), 32'h0);
    end
    @(posedge clk); #1;
    push_grant(1'b0, 32'h10, 32'h0);
    push_resp(1'b0, 1'b1, 32'h8C220004);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("release_mem_req", 32'(mem_req), 32'h1);
    chk("release_mem_addr", mem_addr, 32'h10);
    fetch(32'h10, cyc);

    // Fetch only: minimum latency of 3 cycles with a 1-cycle memory.
    push_grant(1'b0, 32'h10, 32'h0);
    push_resp(1'b0, 1'b1, 32'h8C220004);
    fetch(32'h10, cyc);
    chk("fetch_latency", 32'(cyc - 1), 32'd3);
    repeat (2) @(negedge clk);
    chk("i_rdata_hold", i_rdata, 32'h8C220004);
    @(posedge clk); #1;

    // Simultaneous requests: store first, then fetch.
    push_grant(1'b1, 32'h100, 32'hDEADBEEF);
    push_grant(1'b0, 32'h14, 32'h0);
    push_resp(1'b1, 1'b0, 32'h0);
    push_resp(1'b0, 1'b1, 32'h00000013);
    fork
      fetch(32'h14, cyc);
      data_op(1'b1, 32'h100, 32'hDEADBEEF);
    join

    // Starvation limit: four data grants, one fetch, then data resumes.
    for (int k = 0; k < 4; k++) begin
      push_grant(1'b0, t4_addr[k], 32'h0);
      push_resp(1'b1, 1'b1, t4_data[k]);
    end
    push_grant(1'b0, 32'h18, 32'h0);
    push_resp(1'b0, 1'b1, 32'h24420001);
    for (int k = 4; k < 6; k++) begin
      push_grant(1'b0, t4_addr[k], 32'h0);
      push_resp(1'b1, 1'b1, t4_data[k]);
    end
    fork
      fetch(32'h18, cyc);
      begin
        for (int k = 0; k < 6; k++) data_op(1'b0, t4_addr[k], 32'h0);
      end
    join

    // Abort while the fetch is in flight: access completes, no response.
    push_grant(1'b0, 32'h30, 32'h0);
    i_req = 1'b1; i_addr = 32'h30;
    wait_mem_req(20);
    i_abort = 1'b1;
    @(posedge clk); #1;
    i_abort = 1'b0; i_req = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("aborted_mem_req_idle", 32'(mem_req), 32'h0);
    chk("i_rdata_hold_after_abort", i_rdata, 32'h24420001);

    // Abort in IDLE blocks the fetch grant for that cycle; the next fetch returns new data.
    i_req = 1'b1; i_addr = 32'h40; i_abort = 1'b1;
    @(posedge clk); #1;
    chk("abort_idle_no_grant", 32'(mem_req), 32'h0);
    i_abort = 1'b0;
    push_grant(1'b0, 32'h40, 32'h0);
    push_resp(1'b0, 1'b1, 32'h22222222);
    fetch(32'h40, cyc);

    // Reset in the middle of a data access whose memory never answers.
    resp_enable = 1'b0;
    push_grant(1'b0, 32'h300, 32'h0);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    wait_mem_req(20);
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b0; d_req = 1'b0;
    #1;
    chk("async_reset_mem_req", 32'(mem_req), 32'h0);
    chk("async_reset_d_resp", 32'(d_resp), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1; resp_enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_reset_idle", 32'(mem_req), 32'h0);
    push_grant(1'b0, 32'h10, 32'h0);
    push_resp(1'b0, 1'b1, 32'h8C220004);
    i_req = 1'b1; i_addr = 32'h10;
    @(posedge clk); #1;
    chk("post_reset_grant", 32'(mem_req), 32'h1);
    fetch(32'h10, cyc);

    repeat (10) @(posedge clk);
    #1;
    chk("grant_queue_empty", 32'(grant_q.size()), 32'h0);
    chk("resp_queue_empty", 32'(resp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, expected finish earlier");
    $fatal(1, "watchdog expired");
  end

endmodule
